// File: rtl/mac_carry_normalize_pkg.sv
// Shared widths and state encoding for the MAC column-sum carry normalizer.
// The limb and sum widths are common with the MAC element and the limb store.
package mac_carry_normalize_pkg;

  localparam int unsigned LIMB_W      = 27;
  localparam int unsigned SUM_W       = 64;
  localparam int unsigned CARRY_W     = SUM_W - LIMB_W + 1;
  localparam int unsigned FLUSH_LIMBS = 2;
  localparam int unsigned FCNT_W      = (FLUSH_LIMBS > 1) ? $clog2(FLUSH_LIMBS) : 1;

  typedef enum logic {
    ST_RUN   = 1'b0,
    ST_FLUSH = 1'b1
  } state_e;

endpackage

// File: rtl/mac_carry_normalize.sv
// Folds wide MAC column sums into canonical limbs, least significant first,
// then drains the residual carry as FLUSH_LIMBS trailing limbs.
module mac_carry_normalize
  import mac_carry_normalize_pkg::*;
(
  input  logic              clk,
  input  logic              aclr,
  input  logic [SUM_W-1:0]  in_data,
  input  logic              in_valid,
  input  logic              in_last,
  output logic              in_ready,
  output logic [LIMB_W-1:0] out_limb,
  output logic              out_valid,
  output logic              out_last,
  input  logic              out_ready,
  output logic              busy
);

  state_e              state_q, state_d;
  logic [CARRY_W-1:0]  carry_q, carry_d;
  logic [FCNT_W-1:0]   fcnt_q, fcnt_d;
  logic [LIMB_W-1:0]   limb_q, limb_d;
  logic                valid_q, valid_d;
  logic                last_q, last_d;
  logic                busy_q, busy_d;

  logic                out_free;
  logic                in_fire;
  logic                out_fire;
  logic                flush_end;
  logic [SUM_W:0]      sum;

  assign out_free  = !valid_q || out_ready;
  assign in_ready  = !aclr && (state_q == ST_RUN) && out_free;
  assign in_fire   = in_valid && in_ready;
  assign out_fire  = valid_q && out_ready;
  assign flush_end = (fcnt_q == FCNT_W'(FLUSH_LIMBS - 1));
  assign sum       = {1'b0, in_data} + (SUM_W + 1)'(carry_q);

  assign out_limb  = limb_q;
  assign out_valid = valid_q;
  assign out_last  = last_q;
  assign busy      = busy_q;

  always_ff @(posedge clk) begin
    if (aclr) begin
      state_q <= ST_RUN;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_RUN:   if (in_fire && in_last) state_d = ST_FLUSH;
      ST_FLUSH: if (out_free && flush_end) state_d = ST_RUN;
      default:  state_d = ST_RUN;
    endcase
  end

  // Add/split in RUN, carry drain in FLUSH; everything freezes while the output stalls.
  always_comb begin
    carry_d = carry_q;
    fcnt_d  = fcnt_q;
    limb_d  = limb_q;
    valid_d = valid_q;
    last_d  = last_q;
    busy_d  = busy_q;

    case (state_q)
      ST_RUN: begin
        if (in_fire) begin
          limb_d  = sum[LIMB_W-1:0];
          valid_d = 1'b1;
          last_d  = 1'b0;
          carry_d = sum[SUM_W:LIMB_W];
          fcnt_d  = '0;
        end else if (out_free) begin
          valid_d = 1'b0;
          last_d  = 1'b0;
        end
      end
      ST_FLUSH: begin
        if (out_free) begin
          limb_d  = carry_q[LIMB_W-1:0];
          valid_d = 1'b1;
          last_d  = flush_end;
          carry_d = flush_end ? '0 : (carry_q >> LIMB_W);
          fcnt_d  = flush_end ? '0 : fcnt_q + FCNT_W'(1);
        end
      end
      default: ;
    endcase

    // A new first column may land on the same edge the previous final limb leaves.
    if (out_fire && last_q) busy_d = 1'b0;
    if (in_fire)            busy_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (aclr) begin
      carry_q <= '0;
      fcnt_q  <= '0;
      limb_q  <= '0;
      valid_q <= 1'b0;
      last_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      carry_q <= carry_d;
      fcnt_q  <= fcnt_d;
      limb_q  <= limb_d;
      valid_q <= valid_d;
      last_q  <= last_d;
      busy_q  <= busy_d;
    end
  end

endmodule

// File: tb/tb_mac_carry_normalize.sv
// Bench for mac_carry_normalize: expected limbs come from a bignum sum of
// column_i * 2^(27*i), split into 27-bit chunks.
module tb_mac_carry_normalize;
  import mac_carry_normalize_pkg::*;

  logic              clk = 1'b0;
  logic              aclr;
  logic [SUM_W-1:0]  in_data;
  logic              in_valid;
  logic              in_last;
  logic              in_ready;
  logic [LIMB_W-1:0] out_limb;
  logic              out_valid;
  logic              out_last;
  logic              out_ready;
  logic              busy;

  mac_carry_normalize dut (
    .clk       (clk),
    .aclr      (aclr),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_last   (in_last),
    .in_ready  (in_ready),
    .out_limb  (out_limb),
    .out_valid (out_valid),
    .out_last  (out_last),
    .out_ready (out_ready),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  logic [LIMB_W-1:0] exp_limb_q[$];
  bit                exp_last_q[$];
  int                exp_cnt_q[$];

  logic [SUM_W-1:0]  cols[16];
  int                ncol;
  int                ready_mode = 0;
  bit                gap_en = 1'b0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Downstream ready: steady, fixed 1,0,0 pattern, or random stalls.
  initial begin
    int pat = 0;
    out_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      case (ready_mode)
        0: out_ready = 1'b1;
        1: begin
          out_ready = (pat == 0);
          pat = (pat + 1) % 3;
        end
        default: out_ready = ($urandom_range(0, 3) != 0);
      endcase
    end
  end

  // Output monitor: ordering, payload, last flag, per-operation limb count, stall stability.
  initial begin
    int               lim_cnt = 0;
    bit               prev_stall = 1'b0;
    logic [LIMB_W-1:0] prev_limb = '0;
    logic             prev_last = 1'b0;
    forever begin
      @(negedge clk);
      if (aclr) begin
        lim_cnt    = 0;
        prev_stall = 1'b0;
      end else begin
        if (prev_stall) begin
          chk("hold_valid", 64'(out_valid), 64'd1);
          chk("hold_limb", 64'(out_limb), 64'(prev_limb));
          chk("hold_last", 64'(out_last), 64'(prev_last));
        end
        if (out_valid) chk("busy_with_output", 64'(busy), 64'd1);
        if (out_valid && !out_ready) chk("in_ready_stall", 64'(in_ready), 64'd0);
        if (out_valid && out_ready) begin
          lim_cnt++;
          if (exp_limb_q.size() == 0) begin
            chk("unexpected_limb", 64'd1, 64'd0);
          end else begin
            chk("limb", 64'(out_limb), 64'(exp_limb_q.pop_front()));
            chk("last", 64'(out_last), 64'(exp_last_q.pop_front()));
          end
          if (out_last) begin
            if (exp_cnt_q.size() != 0) chk("limb_count", 64'(lim_cnt), 64'(exp_cnt_q.pop_front()));
            lim_cnt = 0;
          end
        end
        prev_stall = out_valid && !out_ready;
        prev_limb  = out_limb;
        prev_last  = out_last;
      end
    end
  end

  task automatic send_col(input logic [SUM_W-1:0] d, input logic l);
    int w = 0;
    @(posedge clk);
    #1;
    in_valid = 1'b1;
    in_data  = d;
    in_last  = l;
    forever begin
      @(negedge clk);
      if (in_ready) break;
      w++;
      if (w > 500) begin
        chk("accept_timeout", 64'd0, 64'd1);
        break;
      end
      @(posedge clk);
      #1;
    end
  endtask

  task automatic drop_in();
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  // Reference: bignum of all columns weighted by 2^(27*i), split into ncol+2 limbs.
  task automatic run_op();
    logic [511:0] total = '0;
    for (int i = 0; i < ncol; i++) total += 512'(cols[i]) << (LIMB_W * i);
    for (int k = 0; k < ncol + 2; k++) begin
      exp_limb_q.push_back(total[LIMB_W*k +: LIMB_W]);
      exp_last_q.push_back(k == ncol + 1);
    end
    exp_cnt_q.push_back(ncol + 2);
    for (int i = 0; i < ncol; i++) begin
      send_col(cols[i], i == ncol - 1);
      if (gap_en && $urandom_range(0, 7) == 0) begin
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat ($urandom_range(0, 2)) @(posedge clk);
      end
    end
  endtask

  task automatic wait_idle();
    int w = 0;
    forever begin
      @(negedge clk);
      if (exp_limb_q.size() == 0 && !out_valid) break;
      w++;
      if (w > 5000) begin
        chk("idle_timeout", 64'd0, 64'd1);
        break;
      end
    end
    chk("busy_idle", 64'(busy), 64'd0);
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    logic [SUM_W-1:0] r0, r1;
    aclr     = 1'b1;
    in_valid = 1'b0;
    in_data  = '0;
    in_last  = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_out_last", 64'(out_last), 64'd0);
    chk("rst_out_limb", 64'(out_limb), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_in_ready", 64'(in_ready), 64'd0);
    @(posedge clk);
    #1;
    aclr = 1'b0;
    @(negedge clk);
    chk("post_rst_in_ready", 64'(in_ready), 64'd1);

    // Single column 0x0800_0005: limbs 5, 1, 0
    exp_limb_q.push_back(27'h0000005); exp_last_q.push_back(1'b0);
    exp_limb_q.push_back(27'h0000001); exp_last_q.push_back(1'b0);
    exp_limb_q.push_back(27'h0000000); exp_last_q.push_back(1'b1);
    exp_cnt_q.push_back(3);
    send_col(64'h0000_0000_0800_0005, 1'b1);
    drop_in();
    wait_idle();

    // Three all-ones columns, then again under a 1,0,0 stall pattern
    ncol = 3;
    for (int i = 0; i < 3; i++) cols[i] = '1;
    run_op();
    drop_in();
    wait_idle();
    ready_mode = 1;
    run_op();
    drop_in();
    wait_idle();
    ready_mode = 0;

    // Next op offered throughout the flush; must start from zero carry
    ncol = 1;
    cols[0] = '1;
    run_op();
    cols[0] = 64'd5;
    run_op();
    drop_in();
    wait_idle();

    // Reset the cycle after the second of four columns
    r0 = {$urandom, $urandom};
    r1 = {$urandom, $urandom};
    exp_limb_q.push_back(r0[LIMB_W-1:0]);
    exp_last_q.push_back(1'b0);
    send_col(r0, 1'b0);
    send_col(r1, 1'b0);
    @(posedge clk);
    #1;
    aclr    = 1'b1;
    in_data = {$urandom, $urandom};
    @(negedge clk);
    chk("in_ready_in_reset", 64'(in_ready), 64'd0);
    @(posedge clk);
    #1;
    aclr     = 1'b0;
    in_valid = 1'b0;
    @(negedge clk);
    chk("abort_out_valid", 64'(out_valid), 64'd0);
    chk("abort_busy", 64'(busy), 64'd0);
    chk("abort_in_ready", 64'(in_ready), 64'd1);
    ncol = 1;
    cols[0] = 64'h1B;
    run_op();
    drop_in();
    wait_idle();

    // Random operations with random stalls and input gaps
    ready_mode = 2;
    gap_en     = 1'b1;
    for (int op = 0; op < 2000; op++) begin
      ncol = $urandom_range(1, 16);
      for (int i = 0; i < ncol; i++) begin
        case ($urandom_range(0, 3))
          0:       cols[i] = '1;
          1:       cols[i] = 64'($urandom_range(0, 255));
          default: cols[i] = {$urandom, $urandom};
        endcase
      end
      run_op();
      if ($urandom_range(0, 3) == 0) drop_in();
    end
    drop_in();
    wait_idle();
    chk("exp_queue_drained", 64'(exp_limb_q.size()), 64'd0);
    chk("cnt_queue_drained", 64'(exp_cnt_q.size()), 64'd0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
